seg_scan_ctrl: RTL

Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
- Owns the refresh timebase and selects one digit per slot.
- Presents that digit's 4-bit code on bn to the downstream hex-to-7-segment decoder and drives the active-low digit enables.
- Display data is written through a valid/ready handshake into a shadow register and committed only at frame boundaries, so digits never tear mid-frame.

---
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [3:0]        bn,
  output logic [NDIG-1:0]   dig_sel,
  output logic              frame_start
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [4*NDIG-1:0] r_active;
  logic [4*NDIG-1:0] r_shadow;
  logic              r_pending;
  logic              r_wr_ready;
  logic              r_frame_start;
  logic [3:0]        r_bn;
  logic [NDIG-1:0]   w_sel;
  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_commit;
  logic              w_accept;
  logic              w_hide;

  assign w_slot_end  = (r_cnt == CW'(DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(NDIG - 1));
  assign w_idx_nxt   = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
  // wr_ready is the complement of pending, so commit and accept never overlap.
  assign w_commit    = w_frame_end && r_pending;
  assign w_accept    = wr_valid && r_wr_ready;

`ifdef SEG_SCAN_LZB_EN
  logic [NDIG-1:0] r_lzb_mask;
  logic [NDIG-1:0] w_lzb_mask_nxt;
  logic            w_zero_run;

  always_comb begin
    w_lzb_mask_nxt = '0;
    w_zero_run     = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      w_zero_run        = w_zero_run && (r_shadow[4*k +: 4] == 4'h0);
      w_lzb_mask_nxt[k] = w_zero_run;
    end
  end

  // Reset mask matches an all-zero active value: only digit 0 is shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lzb_mask <= {{(NDIG-1){1'b1}}, 1'b0};
    else if (w_commit) r_lzb_mask <= w_lzb_mask_nxt;
  end

  assign w_hide = r_lzb_mask[r_idx];
`else
  assign w_hide = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_BLANK;
    end else begin
      r_cnt   <= w_slot_end ? '0 : r_cnt + CW'(1);
      r_state <= w_state_nxt;
      if (w_slot_end) r_idx <= w_idx_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = '1;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == CW'(BLANK_CYC - 1)) w_state_nxt = ST_SHOW;
      end
      ST_SHOW: begin
        if (!w_hide)    w_sel[r_idx] = 1'b0;
        if (w_slot_end) w_state_nxt  = ST_BLANK;
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active      <= '0;
      r_shadow      <= '0;
      r_pending     <= 1'b0;
      r_wr_ready    <= 1'b1;
      r_frame_start <= 1'b0;
      r_bn          <= 4'h0;
    end else begin
      r_frame_start <= w_frame_end;
      if (w_accept) begin
        r_shadow   <= wr_data;
        r_pending  <= 1'b1;
        r_wr_ready <= 1'b0;
      end else if (w_commit) begin
        r_active   <= r_shadow;
        r_pending  <= 1'b0;
        r_wr_ready <= 1'b1;
      end
      // bn is loaded a full BLANK phase ahead of the digit enable.
      if (w_commit)        r_bn <= r_shadow[3:0];
      else if (w_slot_end) r_bn <= r_active[{w_idx_nxt, 2'b00} +: 4];
    end
  end

  assign wr_ready    = r_wr_ready;
  assign bn          = r_bn;
  assign dig_sel     = w_sel;
  assign frame_start = r_frame_start;

endmodule
